// File: rtl/axi_wr_arbiter.sv
// Shares one AXI write slave port (AW/W/B) among NUM_MASTERS masters; the grant holds for a whole transaction.
// Define AXI_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axi_wr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_BITS   = 32,
   parameter int LEN_BITS    = 8,
   parameter int SIZE_BITS   = 3,
   parameter int DATA_BITS   = 32,
   localparam int GNT_BITS   = $clog2(NUM_MASTERS),
   localparam int STRB_BITS  = DATA_BITS / 8
) (
   input  logic                             aclk,
   input  logic                             areset_n,
   input  logic [NUM_MASTERS-1:0]           m_aw_valid,
   output logic [NUM_MASTERS-1:0]           m_aw_ready,
   input  logic [NUM_MASTERS*ADDR_BITS-1:0] m_aw_addr,
   input  logic [NUM_MASTERS*LEN_BITS-1:0]  m_aw_len,
   input  logic [NUM_MASTERS*SIZE_BITS-1:0] m_aw_size,
   input  logic [NUM_MASTERS*2-1:0]         m_aw_burst,
   input  logic [NUM_MASTERS*4-1:0]         m_aw_cache,
   input  logic [NUM_MASTERS-1:0]           m_w_valid,
   output logic [NUM_MASTERS-1:0]           m_w_ready,
   input  logic [NUM_MASTERS-1:0]           m_w_last,
   input  logic [NUM_MASTERS*DATA_BITS-1:0] m_w_data,
   input  logic [NUM_MASTERS*STRB_BITS-1:0] m_w_strb,
   output logic [NUM_MASTERS-1:0]           m_b_valid,
   input  logic [NUM_MASTERS-1:0]           m_b_ready,
   output logic [NUM_MASTERS*2-1:0]         m_b_resp,
   output logic                             s_aw_valid,
   input  logic                             s_aw_ready,
   output logic [ADDR_BITS-1:0]             s_aw_addr,
   output logic [LEN_BITS-1:0]              s_aw_len,
   output logic [SIZE_BITS-1:0]             s_aw_size,
   output logic [1:0]                       s_aw_burst,
   output logic [3:0]                       s_aw_cache,
   output logic                             s_w_valid,
   input  logic                             s_w_ready,
   output logic [DATA_BITS-1:0]             s_w_data,
   output logic [STRB_BITS-1:0]             s_w_strb,
   output logic                             s_w_last,
   input  logic                             s_b_valid,
   input  logic [1:0]                       s_b_resp,
   output logic                             s_b_ready,
   output logic                             busy,
   output logic [GNT_BITS-1:0]              grant_id,
   output logic                             len_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                 state_q, state_d;
   logic [GNT_BITS-1:0]    grant_q, grant_d;
   logic [GNT_BITS-1:0]    rr_ptr_q, rr_ptr_d;
   logic [LEN_BITS-1:0]    beat_cnt_q, beat_cnt_d;
   logic [LEN_BITS-1:0]    aw_len_q, aw_len_d;
   logic                   len_err_q, len_err_d;

   logic [GNT_BITS-1:0]    winner;
   logic                   found;
   logic [NUM_MASTERS-1:0] gsel;
   logic                   in_addr, in_data, in_resp;

   logic                   sel_aw_valid, sel_w_valid, sel_w_last, sel_b_ready;
   logic [ADDR_BITS-1:0]   sel_aw_addr;
   logic [LEN_BITS-1:0]    sel_aw_len;
   logic [SIZE_BITS-1:0]   sel_aw_size;
   logic [1:0]             sel_aw_burst;
   logic [3:0]             sel_aw_cache;
   logic [DATA_BITS-1:0]   sel_w_data;
   logic [STRB_BITS-1:0]   sel_w_strb;

   // Winner: first requester at or above the pointer, else wrap to the lowest requester.
   always_comb begin
      winner = '0;
      found  = 1'b0;
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
`else
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (!found && m_aw_valid[k] && (k >= int'(rr_ptr_q))) begin
            winner = GNT_BITS'(k);
            found  = 1'b1;
         end
      end
`endif
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (!found && m_aw_valid[k]) begin
            winner = GNT_BITS'(k);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_aw_valid = 1'b0;
      sel_aw_addr  = '0;
      sel_aw_len   = '0;
      sel_aw_size  = '0;
      sel_aw_burst = '0;
      sel_aw_cache = '0;
      sel_w_valid  = 1'b0;
      sel_w_data   = '0;
      sel_w_strb   = '0;
      sel_w_last   = 1'b0;
      sel_b_ready  = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (gsel[k]) begin
            sel_aw_valid = m_aw_valid[k];
            sel_aw_addr  = m_aw_addr[k*ADDR_BITS +: ADDR_BITS];
            sel_aw_len   = m_aw_len[k*LEN_BITS +: LEN_BITS];
            sel_aw_size  = m_aw_size[k*SIZE_BITS +: SIZE_BITS];
            sel_aw_burst = m_aw_burst[k*2 +: 2];
            sel_aw_cache = m_aw_cache[k*4 +: 4];
            sel_w_valid  = m_w_valid[k];
            sel_w_data   = m_w_data[k*DATA_BITS +: DATA_BITS];
            sel_w_strb   = m_w_strb[k*STRB_BITS +: STRB_BITS];
            sel_w_last   = m_w_last[k];
            sel_b_ready  = m_b_ready[k];
         end
      end
   end

   assign in_addr = (state_q == ADDR);
   assign in_data = (state_q == DATA);
   assign in_resp = (state_q == RESP);

   assign s_aw_valid = in_addr && sel_aw_valid;
   assign s_aw_addr  = in_addr ? sel_aw_addr  : '0;
   assign s_aw_len   = in_addr ? sel_aw_len   : '0;
   assign s_aw_size  = in_addr ? sel_aw_size  : '0;
   assign s_aw_burst = in_addr ? sel_aw_burst : '0;
   assign s_aw_cache = in_addr ? sel_aw_cache : '0;
   assign s_w_valid  = in_data && sel_w_valid;
   assign s_w_data   = in_data ? sel_w_data : '0;
   assign s_w_strb   = in_data ? sel_w_strb : '0;
   // Last is derived from the latched burst length, never trusted from the master.
   assign s_w_last   = in_data && (beat_cnt_q == aw_len_q);
   assign s_b_ready  = in_resp && sel_b_ready;

   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;
   assign len_err  = len_err_q;

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign gsel[gi]            = (grant_q == GNT_BITS'(gi));
      assign m_aw_ready[gi]      = gsel[gi] && in_addr && s_aw_ready;
      assign m_w_ready[gi]       = gsel[gi] && in_data && s_w_ready;
      assign m_b_valid[gi]       = gsel[gi] && in_resp && s_b_valid;
      assign m_b_resp[gi*2 +: 2] = (gsel[gi] && in_resp) ? s_b_resp : 2'b00;
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      aw_len_d   = aw_len_q;
      len_err_d  = len_err_q;
      case (state_q)
         IDLE: begin
            if (|m_aw_valid) begin
               grant_d = winner;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (s_aw_valid && s_aw_ready) begin
               aw_len_d   = s_aw_len;
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (s_w_valid && s_w_ready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (sel_w_last != s_w_last) len_err_d = 1'b1;
               if (s_w_last) state_d = RESP;
            end
         end
         RESP: begin
            if (s_b_valid && s_b_ready) begin
               rr_ptr_d = (int'(grant_q) == NUM_MASTERS - 1) ? '0 : grant_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         aw_len_q   <= '0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         aw_len_q   <= aw_len_d;
         len_err_q  <= len_err_d;
      end
   end

endmodule
